// File: rtl/histogram_bin_accumulator.sv
// ============================================================================
// histogram_bin_accumulator
//
// Purpose:
//   This block stores the time-correlation histogram. It sits between the plot
//   distributer and the host readout. Each rising edge of Memory_add is one
//   correlation event, and it adds +1 to the RAM bin selected by Addr. The
//   block also has a host read port and a sequencer that clears the whole
//   histogram. Everything runs on one clock domain.
//
// Parameters:
//   ADDR_W  bin address width, NUM_BINS = 2**ADDR_W (bin 128 = zero delay)
//   CNT_W   per-bin counter width, counters saturate at 2**CNT_W-1
//
// Ports:
//   clk         system clock, posedge
//   rst         synchronous active-high reset
//   Addr        bin address, stable while Memory_add is high
//   Memory_add  increment request level; one event per rising edge
//   rd_req      host read strobe (1 cycle), honoured only when idle
//   rd_addr     bin to read, sampled with rd_req
//   rd_data     bin count, updated with rd_valid and held until next read
//   rd_valid    1-cycle pulse marking new rd_data
//   clr_start   start clearing all bins (1 cycle)
//   clr_busy    high while the clear sweep runs
//   sat_flag    sticky, some bin reached its maximum count
//   drop_cnt    saturating count of lost events
//
// FSM states:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | arbitrate: clear > pending increment > host read
//   S_INC_RD  | RAM returns bin value; form value+1 (or hold at max)
//   S_INC_WR  | write incremented value back; free the pending slot
//   S_RD_WAIT | RAM returns host read data; present it with rd_valid
//   S_CLEAR   | write zero to one bin per cycle, 0 .. NUM_BINS-1
// ============================================================================
module histogram_bin_accumulator #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              Memory_add,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              sat_flag,
    output logic [15:0]       drop_cnt
);

    localparam int NUM_BINS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INC_RD  = 3'd1,
        S_INC_WR  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ma_prev;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_addr;
    logic              r_clr_req;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_wr_data;
    logic [CNT_W-1:0]  r_ram_q;
    logic [CNT_W-1:0]  r_mem [NUM_BINS];

    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_clr_busy;
    logic              r_sat_flag;
    logic [15:0]       r_drop_cnt;

    logic              w_edge;
    logic              w_take_clr;
    logic              w_take_inc;
    logic              w_take_rd;
    logic              w_slot_free;
    logic              w_clr_done;
    logic              w_drop_edge;
    logic              w_drop_pend;
    logic              w_accept;
    logic [1:0]        w_drop_inc;
    logic [16:0]       w_drop_sum;

    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [CNT_W-1:0]  w_ram_wdata;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign clr_busy = r_clr_busy;
    assign sat_flag = r_sat_flag;
    assign drop_cnt = r_drop_cnt;

    // ------------------------------------------------------------------------
    // Event arbitration and next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_edge      = Memory_add & ~r_ma_prev;
        w_take_clr  = 1'b0;
        w_take_inc  = 1'b0;
        w_take_rd   = 1'b0;
        w_slot_free = (r_state == S_INC_WR);
        w_clr_done  = (r_state == S_CLEAR) && (r_ptr == PTR_LAST);
        w_state_nxt = r_state;

        if (r_state == S_IDLE) begin
            w_take_clr = clr_start | r_clr_req;
            w_take_inc = ~w_take_clr & r_pend_vld;
            w_take_rd  = ~w_take_clr & ~r_pend_vld & rd_req;
        end

        // When a clear starts, it throws away any queued event and any edge in
        // the same cycle. The slot frees during INC_WR, so an edge arriving in
        // that cycle is still accepted.
        w_drop_edge = w_edge & (r_clr_busy | w_take_clr | (r_pend_vld & ~w_slot_free));
        w_drop_pend = w_take_clr & r_pend_vld;
        w_accept    = w_edge & ~w_drop_edge;
        w_drop_inc  = {1'b0, w_drop_edge} + {1'b0, w_drop_pend};
        w_drop_sum  = {1'b0, r_drop_cnt} + {15'd0, w_drop_inc};

        case (r_state)
            S_IDLE: begin
                if (w_take_clr) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_take_inc) begin
                    w_state_nxt = S_INC_RD;
                end else if (w_take_rd) begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_INC_RD:  w_state_nxt = S_INC_WR;
            S_INC_WR:  w_state_nxt = S_IDLE;
            S_RD_WAIT: w_state_nxt = S_IDLE;
            S_CLEAR: begin
                if (w_clr_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // RAM port steering (single port: one read or one write per cycle)
    // ------------------------------------------------------------------------
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = r_pend_addr;
        w_ram_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_take_rd) begin
                    w_ram_addr = rd_addr;
                end
            end
            S_INC_WR: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = r_wr_data;
            end
            S_CLEAR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_ptr;
            end
            default: begin
                w_ram_we = 1'b0;
            end
        endcase
    end

    // The RAM contents are not reset on purpose; a clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end else begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ma_prev   <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_clr_req   <= 1'b0;
            r_ptr       <= '0;
            r_wr_data   <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_clr_busy  <= 1'b0;
            r_sat_flag  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ma_prev <= Memory_add;

            if (w_accept) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= Addr;
            end else if (w_slot_free || w_drop_pend) begin
                r_pend_vld <= 1'b0;
            end

            // A clear that arrives while an increment is in flight waits here
            // until the FSM gets back to IDLE. A clear that arrives during an
            // active sweep is ignored.
            if (w_take_clr) begin
                r_clr_req <= 1'b0;
            end else if (clr_start && (r_state != S_IDLE) && (r_state != S_CLEAR)) begin
                r_clr_req <= 1'b1;
            end

            if (w_take_clr) begin
                r_ptr <= '0;
            end else if (r_state == S_CLEAR) begin
                r_ptr <= r_ptr + PTR_ONE;
            end

            if (w_take_clr) begin
                r_clr_busy <= 1'b1;
            end else if (w_clr_done) begin
                r_clr_busy <= 1'b0;
            end

            if (r_state == S_INC_RD) begin
                r_wr_data <= (r_ram_q == CNT_MAX) ? r_ram_q : r_ram_q + CNT_ONE;
            end

            if (w_clr_done) begin
                r_sat_flag <= 1'b0;
            end else if ((r_state == S_INC_RD) && (r_ram_q == CNT_MAX)) begin
                r_sat_flag <= 1'b1;
            end

            r_rd_valid <= (r_state == S_RD_WAIT);
            if (r_state == S_RD_WAIT) begin
                r_rd_data <= r_ram_q;
            end

            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_histogram_bin_accumulator.sv
module tb_histogram_bin_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  Addr;
    logic        Memory_add;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        clr_start;

    logic [15:0] rd_data_a;
    logic        rd_valid_a, clr_busy_a, sat_a;
    logic [15:0] drop_a;
    logic [3:0]  rd_data_b;
    logic        rd_valid_b, clr_busy_b, sat_b;
    logic [15:0] drop_b;

    always #5 clk = ~clk;

    histogram_bin_accumulator #(.ADDR_W(8), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .Addr(Addr), .Memory_add(Memory_add),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .clr_start(clr_start), .clr_busy(clr_busy_a), .sat_flag(sat_a), .drop_cnt(drop_a)
    );

    histogram_bin_accumulator #(.ADDR_W(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .Addr(Addr), .Memory_add(Memory_add),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .clr_start(clr_start), .clr_busy(clr_busy_b), .sat_flag(sat_b), .drop_cnt(drop_b)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Reference model. It works one event at a time. An accepted event keeps
    // the store busy for three cycles, and edges that arrive inside that
    // window are lost. A clear zeroes every bin and loses every edge during
    // the 257 cycles from the clear-start edge to the end of the sweep.
    int cyc = 0;
    int free_cyc = 0;
    int clr_end = -1;
    int clr_pend_at = -1;
    bit prev_ma = 1'b0;
    int cnt [256];
    int exp_drop = 0;
    bit exp_sat4 = 1'b0;

    int pool [8] = '{0, 5, 64, 127, 128, 129, 200, 255};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void start_clear(input int s);
        clr_end  = s + 256;
        free_cyc = s + 257;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        exp_sat4 = 1'b0;
    endfunction

    function automatic void model_edge(input int c, input int a);
        if (c <= clr_end || c < free_cyc) begin
            exp_drop++;
        end else begin
            if (cnt[a] >= 15) exp_sat4 = 1'b1;
            cnt[a]++;
            free_cyc = c + 3;
        end
    endfunction

    // Advance one clock: first update the model for the coming posedge, then
    // sample the DUT 1 time unit after the edge.
    task automatic tick();
        if (rst) begin
            exp_drop = 0;
            exp_sat4 = 1'b0;
            free_cyc = cyc + 1;
            clr_end = -1;
            clr_pend_at = -1;
            prev_ma = 1'b0;
        end else begin
            if (clr_pend_at == cyc) begin
                start_clear(cyc);
                clr_pend_at = -1;
            end
            if (Memory_add && !prev_ma) model_edge(cyc, int'(Addr));
            prev_ma = Memory_add;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit model_idle();
        return (cyc >= free_cyc + 1) && (cyc > clr_end + 1) && (clr_pend_at < 0);
    endfunction

    task automatic settle();
        Memory_add = 1'b0;
        for (int i = 0; i < 600 && !model_idle(); i++) tick();
        tick();
        tick();
    endtask

    task automatic issue_clear_idle();
        clr_start = 1'b1;
        start_clear(cyc);
        tick();
        clr_start = 1'b0;
    endtask

    task automatic do_read(input string tag, input int a);
        rd_req = 1'b1;
        rd_addr = 8'(a);
        tick();
        rd_req = 1'b0;
        tick();
        check({tag, "_valid"}, {31'd0, rd_valid_a & rd_valid_b}, 32'd1);
        check({tag, "_data16"}, {16'd0, rd_data_a}, 32'(lim(cnt[a], 65535)));
        check({tag, "_data4"}, {28'd0, rd_data_b}, 32'(lim(cnt[a], 15)));
        tick();
        check({tag, "_pulse"}, {31'd0, rd_valid_a | rd_valid_b}, 32'd0);
    endtask

    task automatic pulse_events(input int a, input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            Addr = 8'(a);
            Memory_add = 1'b1;
            for (int j = 0; j < hi; j++) tick();
            Memory_add = 1'b0;
            for (int j = 0; j < lo; j++) tick();
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_drop16"}, {16'd0, drop_a}, 32'(exp_drop));
        check({tag, "_drop4"}, {16'd0, drop_b}, 32'(exp_drop));
        check({tag, "_sat16"}, {31'd0, sat_a}, 32'd0);
        check({tag, "_sat4"}, {31'd0, sat_b}, {31'd0, exp_sat4});
    endtask

    initial begin
        int busy;
        int d0;
        rst = 1'b1;
        Addr = 8'd0;
        Memory_add = 1'b0;
        rd_req = 1'b0;
        rd_addr = 8'd0;
        clr_start = 1'b0;
        for (int i = 0; i < 256; i++) cnt[i] = 0;
        repeat (3) tick();
        check("rst_rd_data", {16'd0, rd_data_a}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid_a}, 32'd0);
        check("rst_clr_busy", {31'd0, clr_busy_a}, 32'd0);
        check("rst_sat", {31'd0, sat_a | sat_b}, 32'd0);
        check("rst_drop", {16'd0, drop_a}, 32'd0);
        rst = 1'b0;
        tick();

        // Full clear. A second clr_start during the sweep must not restart it.
        issue_clear_idle();
        busy = 0;
        for (int i = 0; i < 300; i++) begin
            if (!clr_busy_a) break;
            busy++;
            clr_start = (i == 100);
            tick();
            clr_start = 1'b0;
        end
        check("clr_busy_len", 32'(busy), 32'd256);
        settle();
        do_read("init_b0", 0);
        do_read("init_b128", 128);
        do_read("init_b255", 255);

        // Ten separate events on the zero-delay bin.
        pulse_events(128, 10, 5, 1);
        settle();
        do_read("zd_b128", 128);
        do_read("zd_b127", 127);
        do_read("zd_b129", 129);
        check_status("zd");

        // A level held high counts only once.
        pulse_events(130, 1, 50, 1);
        settle();
        do_read("held_b130", 130);

        // Edges spaced closely, inside the 3-cycle service window.
        pulse_events(10, 3, 1, 1);
        settle();
        do_read("close_b10", 10);
        check_status("close");

        // Saturation of the 4-bit instance.
        pulse_events(5, 17, 2, 2);
        settle();
        do_read("sat_b5", 5);
        check_status("sat");

        // Events that arrive while a clear sweep is running are dropped.
        d0 = exp_drop;
        issue_clear_idle();
        pulse_events(64, 6, 3, 7);
        settle();
        do_read("clr_b64", 64);
        do_read("clr_b5", 5);
        check("clr_drops", 32'(exp_drop - d0), 32'd6);
        check_status("clr");

        // clr_start the cycle after an event is queued: the queued event is discarded.
        Addr = 8'd3;
        Memory_add = 1'b1;
        tick();
        clr_start = 1'b1;
        exp_drop++;
        start_clear(cyc);
        tick();
        clr_start = 1'b0;
        check("disc_busy", {31'd0, clr_busy_a}, 32'd1);
        settle();
        do_read("disc_b3", 3);
        check_status("disc");

        // clr_start while an increment is in flight is held until IDLE.
        Addr = 8'd3;
        Memory_add = 1'b1;
        tick();
        tick();
        clr_start = 1'b1;
        clr_pend_at = cyc + 2;
        tick();
        clr_start = 1'b0;
        check("latch_busy0", {31'd0, clr_busy_a}, 32'd0);
        tick();
        check("latch_busy1", {31'd0, clr_busy_a}, 32'd0);
        tick();
        check("latch_busy2", {31'd0, clr_busy_a}, 32'd1);
        settle();
        do_read("latch_b3", 3);
        check_status("latch");

        // Randomised traffic with an occasional clear.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 400; i++) begin
                if (!Memory_add) Addr = 8'(pool[$urandom_range(0, 7)]);
                Memory_add = ($urandom_range(0, 2) != 0) ? ~Memory_add : Memory_add;
                if ($urandom_range(0, 299) == 0 && model_idle()) begin
                    issue_clear_idle();
                end else begin
                    tick();
                end
            end
            settle();
            for (int k = 0; k < 8; k++) do_read($sformatf("rnd%0d_b%0d", r, pool[k]), pool[k]);
            check_status($sformatf("rnd%0d", r));
        end

        // Reset during a clear sweep stops it at once.
        issue_clear_idle();
        repeat (50) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_busy", {31'd0, clr_busy_a | clr_busy_b}, 32'd0);
        check("rst_mid_drop", {16'd0, drop_a}, 32'd0);
        rst = 1'b0;
        tick();
        issue_clear_idle();
        settle();
        pulse_events(200, 2, 2, 2);
        settle();
        do_read("post_rst_b200", 200);
        do_read("post_rst_b0", 0);
        check_status("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
